// File: rtl/bit_generator_if.sv
// Symbol request/response signals between the frame sequencer and the WS2812B bit generator.
interface bit_generator_if;
  logic [1:0] genMode;
  logic       doGen;
  logic       theBit;
  logic       genDone;

  modport master (
    output genMode,
    output doGen,
    input  theBit,
    input  genDone
  );

  modport slave (
    input  genMode,
    input  doGen,
    output theBit,
    output genDone
  );
endinterface

// File: rtl/bit_generator.sv
// WS2812B symbol generator: emits one data '0', data '1', RET or blank symbol per request
// and pulses genDone in the symbol's final low cycle, chaining back-to-back requests without gaps.
module bit_generator #(
  parameter int T0H_CYC = 40,
  parameter int T0L_CYC = 85,
  parameter int T1H_CYC = 80,
  parameter int T1L_CYC = 45,
  parameter int RET_CYC = 6000,
  parameter int CNT_W   = 13
) (
  input  logic            clk,
  input  logic            reset,
  bit_generator_if.slave  gen
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] HIGH = 2'd1;
  localparam logic [1:0] LOW  = 2'd2;

  localparam logic [1:0] MODE_RET   = 2'b00;
  localparam logic [1:0] MODE_BLANK = 2'b01;
  localparam logic [1:0] MODE_ZERO  = 2'b10;

  logic [1:0]       state, nextState;
  logic [1:0]       modeReg, nextMode;
  logic [CNT_W-1:0] counter, nextCounter;

  function automatic logic [CNT_W-1:0] highLast(input logic [1:0] mode);
    return mode[0] ? CNT_W'(T1H_CYC - 1) : CNT_W'(T0H_CYC - 1);
  endfunction

  function automatic logic [CNT_W-1:0] lowLast(input logic [1:0] mode);
    logic [CNT_W-1:0] last;
    case (mode)
      MODE_RET:   last = CNT_W'(RET_CYC - 1);
      MODE_BLANK: last = CNT_W'(T0H_CYC + T0L_CYC - 1);
      MODE_ZERO:  last = CNT_W'(T0L_CYC - 1);
      default:    last = CNT_W'(T1L_CYC - 1);
    endcase
    return last;
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    nextState   = state;
    nextMode    = modeReg;
    nextCounter = counter + CNT_W'(1);

    case (state)
      IDLE: begin
        nextCounter = '0;
        if (gen.doGen) begin
          nextMode  = gen.genMode;
          nextState = gen.genMode[1] ? HIGH : LOW;
        end
      end
      HIGH: begin
        if (counter == highLast(modeReg)) begin
          nextState   = LOW;
          nextCounter = '0;
        end
      end
      LOW: begin
        // Final low cycle: a held request starts the next symbol with no idle gap.
        if (counter == lowLast(modeReg)) begin
          nextCounter = '0;
          if (gen.doGen) begin
            nextMode  = gen.genMode;
            nextState = gen.genMode[1] ? HIGH : LOW;
          end else begin
            nextState = IDLE;
          end
        end
      end
      default: begin
        nextState   = IDLE;
        nextCounter = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state values so they line up with the phase they describe.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (reset) begin
      state       <= IDLE;
      modeReg     <= MODE_RET;
      counter     <= '0;
      gen.theBit  <= 1'b0;
      gen.genDone <= 1'b0;
    end else begin
      state       <= nextState;
      modeReg     <= nextMode;
      counter     <= nextCounter;
      gen.theBit  <= (nextState == HIGH);
      gen.genDone <= (nextState == LOW) && (nextCounter == lowLast(nextMode));
    end
  end

endmodule

// File: tb/tb_bit_generator.sv
// Scoreboard bench for bit_generator: the driver queues expected symbols, a negedge monitor measures them.
`timescale 1ns/1ps
module tb_bit_generator;

  typedef struct {
    int startCyc;
    int hi;
    int lo;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc = 0;
  int   compared = 0;
  int   failed = 0;
  exp_t expQ[$];

  bit_generator_if genIf();

  bit_generator dut (
    .clk   (clk),
    .reset (reset),
    .gen   (genIf.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint actual, input longint expected);
    compared++;
    if (actual !== expected) begin
      failed++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, actual, expected);
    end
  endtask

  // Hand-tabulated symbol lengths at 100 MHz.
  function automatic int hiLen(input logic [1:0] m);
    case (m)
      2'b10:   return 40;
      2'b11:   return 80;
      default: return 0;
    endcase
  endfunction

  function automatic int loLen(input logic [1:0] m);
    case (m)
      2'b00:   return 6000;
      2'b01:   return 125;
      2'b10:   return 85;
      default: return 45;
    endcase
  endfunction

  // Monitor: measures each symbol from its expected start to genDone.
  initial begin
    int hiSeen = 0;
    int loSeen = 0;
    int shapeBad = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        expQ.delete();
        hiSeen = 0;
        loSeen = 0;
        shapeBad = 0;
      end else if (expQ.size() == 0 || cyc < expQ[0].startCyc) begin
        check("idle", {genIf.theBit, genIf.genDone}, 0);
      end else begin
        if (genIf.theBit) begin
          if (loSeen > 0) shapeBad = 1;
          hiSeen++;
        end else begin
          loSeen++;
        end
        if (genIf.genDone) begin
          if (genIf.theBit) shapeBad = 1;
          check("doneCycle", cyc, expQ[0].startCyc + expQ[0].hi + expQ[0].lo - 1);
          check("highCount", hiSeen, expQ[0].hi);
          check("lowCount", loSeen, expQ[0].lo);
          check("shape", shapeBad, 0);
          void'(expQ.pop_front());
          hiSeen = 0;
          loSeen = 0;
          shapeBad = 0;
        end
      end
    end
  end

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic waitUntil(input int t);
    while (cyc < t) stepCycle();
  endtask

  // Issue n chained symbols; the next mode is applied 60 cycles into the current symbol.
  task automatic runSeq(input logic [7:0] modes, input int n, output int firstStart, output int endCyc);
    int starts[4];
    int s;
    exp_t e;
    genIf.genMode = modes[1:0];
    genIf.doGen   = 1'b1;
    s = cyc + 1;
    firstStart = s;
    for (int i = 0; i < n; i++) begin
      e.startCyc = s;
      e.hi = hiLen(modes[2*i +: 2]);
      e.lo = loLen(modes[2*i +: 2]);
      expQ.push_back(e);
      starts[i] = s;
      s += e.hi + e.lo;
    end
    endCyc = s - 1;
    for (int i = 0; i < n; i++) begin
      if (i < n - 1) begin
        waitUntil(starts[i] + 60);
        genIf.genMode = modes[2*(i+1) +: 2];
      end else begin
        waitUntil(starts[i]);
        genIf.doGen = 1'b0;
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected completion", cyc);
    compared++;
    failed++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

  initial begin
    int st;
    int en;
    exp_t e;

    reset = 1'b1;
    genIf.doGen = 1'b0;
    genIf.genMode = 2'b00;
    repeat (2) stepCycle();
    check("resetBit", genIf.theBit, 0);
    check("resetDone", genIf.genDone, 0);
    reset = 1'b0;
    repeat (50) stepCycle();

    // Data '0' held: 40 high / 85 low, back to back.
    runSeq(8'b00_10_10_10, 3, st, en);
    waitUntil(en + 10);

    // Data '1' held: 80 high / 45 low.
    runSeq(8'b00_11_11_11, 3, st, en);
    waitUntil(en + 10);

    // RET: 6000 low cycles.
    runSeq(8'b00_00_00_00, 1, st, en);
    waitUntil(st + 259);
    check("retMidBit", genIf.theBit, 0);
    check("retMidDone", genIf.genDone, 0);
    waitUntil(en + 10);

    // Blank, then a '0' whose mode input switches to '1' mid-symbol.
    runSeq(8'b00_00_00_01, 1, st, en);
    waitUntil(en + 10);
    runSeq(8'b00_11_11_10, 3, st, en);
    waitUntil(en + 10);

    // Reset during the HIGH phase of a '1' aborts it without genDone.
    genIf.genMode = 2'b11;
    genIf.doGen = 1'b1;
    e.startCyc = cyc + 1;
    e.hi = 80;
    e.lo = 45;
    expQ.push_back(e);
    st = cyc + 1;
    stepCycle();
    genIf.doGen = 1'b0;
    waitUntil(st + 20);
    reset = 1'b1;
    stepCycle();
    check("abortBit", genIf.theBit, 0);
    check("abortDone", genIf.genDone, 0);
    stepCycle();
    reset = 1'b0;
    repeat (20) stepCycle();
    runSeq(8'b00_00_00_11, 1, st, en);
    waitUntil(en + 10);

    check("queueEmpty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule
